// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin over WIDTH bits, DIGIT bits per clock,
// with a start/busy/done handshake and registered borrow-out and signed overflow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned DigitSafe = (DIGIT == 0) ? 1 : DIGIT;
  localparam int unsigned N         = WIDTH / DigitSafe;
  localparam int unsigned CntW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DigitSafe) != 0) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT must satisfy 1 <= DIGIT <= WIDTH and divide WIDTH");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  logic             a_sign_q, b_sign_q;
  logic             busy_q, done_q, bout_q, ovf_q;
  logic [WIDTH-1:0] d_q;

  logic [DIGIT-1:0] diff;
  logic             br;
  logic [WIDTH-1:0] r_next;

  // Ripple the low DIGIT operand bits through a chain of full-subtractor cells.
  always_comb begin
    diff = '0;
    br   = br_q;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i] = a_sr_q[i] ^ b_sr_q[i] ^ br;
      br      = (~a_sr_q[i] & b_sr_q[i]) | (~(a_sr_q[i] ^ b_sr_q[i]) & br);
    end
    // New digit enters at the top; after N steps the LSB digit has reached bit 0.
    r_next = (r_sr_q >> DIGIT) | (WIDTH'(diff) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            r_sr_q   <= '0;
            br_q     <= bin;
            cnt_q    <= '0;
            a_sign_q <= a[WIDTH-1];
            b_sign_q <= b[WIDTH-1];
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_sr_q <= a_sr_q >> DIGIT;
          b_sr_q <= b_sr_q >> DIGIT;
          r_sr_q <= r_next;
          br_q   <= br;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            d_q     <= r_next;
            bout_q  <= br;
            ovf_q   <= (a_sign_q != b_sign_q) && (r_next[WIDTH-1] != a_sign_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three configurations (W1/D1, W8/D1, W8/D4),
// directed vectors with hand-computed results, checked by a done-driven monitor.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start0, bin0, busy0, done0, bout0, ovf0;
  logic [0:0] a0, b0, d0;
  logic       start1, bin1, busy1, done1, bout1, ovf1;
  logic [7:0] a1, b1, d1;
  logic       start2, bin2, busy2, done2, bout2, ovf2;
  logic [7:0] a2, b2, d2;

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .bin(bin0),
    .busy(busy0), .done(done0), .d(d0), .bout(bout0), .ovf(ovf0)
  );
  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
  );
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .d(d2), .bout(bout2), .ovf(ovf2)
  );

  logic       dn[3], bz[3], bo[3], ov[3];
  logic [7:0] dv[3];
  assign dn[0] = done0;  assign bz[0] = busy0;  assign bo[0] = bout0;
  assign ov[0] = ovf0;   assign dv[0] = {7'b0, d0};
  assign dn[1] = done1;  assign bz[1] = busy1;  assign bo[1] = bout1;
  assign ov[1] = ovf1;   assign dv[1] = d1;
  assign dn[2] = done2;  assign bz[2] = busy2;  assign bo[2] = bout2;
  assign ov[2] = ovf2;   assign dv[2] = d2;

  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  d;
    logic        bout;
    logic        ovf;
    logic [31:0] cyc;
    logic [7:0]  busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   bcnt[3] = '{0, 0, 0};
  int   ndone[3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse and counts busy cycles per operation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        bcnt[i] = 0;
      end else if (dn[i]) begin
        if (sb.size() == 0 || sb[0].inst != 2'(i)) begin
          n_vec++;
          n_fail++;
          $display("FAIL inst%0d unexpected_done: got done=1 at cycle %0d, expected none", i, cyc);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("inst%0d d", i), 32'(dv[i]), 32'(mon_e.d));
          check($sformatf("inst%0d bout", i), 32'(bo[i]), 32'(mon_e.bout));
          check($sformatf("inst%0d ovf", i), 32'(ov[i]), 32'(mon_e.ovf));
          check($sformatf("inst%0d done_cycle", i), 32'(cyc), mon_e.cyc);
          check($sformatf("inst%0d busy_cycles", i), 32'(bcnt[i]), 32'(mon_e.busy));
        end
        ndone[i]++;
        bcnt[i] = 0;
      end else if (bz[i]) begin
        bcnt[i]++;
      end
    end
  end

  task automatic drive(input int inst, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi);
    case (inst)
      0: begin start0 = s; a0 = av[0]; b0 = bv[0]; bin0 = bi; end
      1: begin start1 = s; a1 = av; b1 = bv; bin1 = bi; end
      default: begin start2 = s; a2 = av; b2 = bv; bin2 = bi; end
    endcase
  endtask

  function automatic int n_of(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 8 : 2;
  endfunction

  task automatic push_exp(input int inst, input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.inst = 2'(inst);
    e.d    = ed;
    e.bout = eb;
    e.ovf  = eo;
    e.cyc  = 32'(cyc + 1 + n_of(inst));
    e.busy = 8'(n_of(inst) - 1);
    sb.push_back(e);
  endtask

  // Called just after a falling edge; start is held for exactly one rising edge.
  task automatic issue(input int inst, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    drive(inst, 1'b1, av, bv, bi);
    if (push) push_exp(inst, ed, eb, eo);
    @(negedge clk);
    drive(inst, 1'b0, av, bv, bi);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [7:0] d_tab    = 8'b1001_0110;
  logic [7:0] bout_tab = 8'b1000_1110;
  logic [7:0] ovf_tab  = 8'b0010_0100;
  logic [2:0] abc;
  int         nd;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inst%0d reset busy", i), 32'(bz[i]), 32'd0);
      check($sformatf("inst%0d reset done", i), 32'(dn[i]), 32'd0);
      check($sformatf("inst%0d reset d", i), 32'(dv[i]), 32'd0);
      check($sformatf("inst%0d reset bout", i), 32'(bo[i]), 32'd0);
      check($sformatf("inst%0d reset ovf", i), 32'(ov[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-subtractor truth table on the 1-bit instance.
    for (int v = 0; v < 8; v++) begin
      abc = 3'(v);
      issue(0, {7'b0, abc[2]}, {7'b0, abc[1]}, abc[0], {7'b0, d_tab[v]}, bout_tab[v],
            ovf_tab[v], 1'b1);
      wait_idle();
    end

    issue(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); wait_idle();
    issue(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1); wait_idle();
    issue(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1); wait_idle();

    // DIGIT=4: start held through the run with different operands must be ignored.
    nd = ndone[2];
    drive(2, 1'b1, 8'h3C, 8'h5A, 1'b1);
    push_exp(2, 8'hE1, 1'b1, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(2, 1'b0, 8'hFF, 8'hFF, 1'b0);
    wait_idle();
    repeat (4) @(negedge clk);
    check("inst2 held_start_done_count", 32'(ndone[2]), 32'(nd + 1));
    check("inst2 held_start_d_kept", 32'(dv[2]), 32'h0000_00E1);

    // Back-to-back: second start lands in the done cycle of the first.
    issue(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    issue(1, 8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of a run.
    issue(1, 8'h05, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("inst1 busy_before_reset", 32'(bz[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("inst1 midrun_reset busy", 32'(bz[1]), 32'd0);
    check("inst1 midrun_reset done", 32'(dn[1]), 32'd0);
    check("inst1 midrun_reset d", 32'(dv[1]), 32'd0);
    check("inst1 midrun_reset bout", 32'(bo[1]), 32'd0);
    check("inst1 midrun_reset ovf", 32'(ov[1]), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    nd = ndone[1];
    repeat (15) @(negedge clk);
    check("inst1 no_done_after_abort", 32'(ndone[1]), 32'(nd));
    issue(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
